// File: rtl/m2_input_buffer_pkg.sv
// Shared constants for the M/2 channelizer buffers: RAM latency, skid FIFO sizing and
// read-FSM encodings common to the analysis input buffer and synthesis output buffer.
package m2_input_buffer_pkg;

    localparam int unsigned MAX_FFT_SIZE  = 2048;
    localparam int unsigned RAM_LATENCY   = 3;
    localparam int unsigned FIFO_DEPTH    = 8;
    // One slot per read in flight plus the read being issued this cycle.
    localparam int unsigned FIFO_AF_LEVEL = RAM_LATENCY + 1;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t S_IDLE  = 2'd0;
    localparam rd_state_t S_READ0 = 2'd1;
    localparam rd_state_t S_READ1 = 2'd2;

endpackage

// File: rtl/dp_block_read_first_ram.sv
// Simple dual-port block RAM, read-first, with a fixed RAM_LATENCY-deep read pipeline.
// The array itself is not reset so it maps onto block RAM.
module dp_block_read_first_ram
    import m2_input_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] pipe_q [RAM_LATENCY];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        pipe_q[0] <= mem[raddr];
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/m2_axis_skid_fifo.sv
// Small output skid FIFO: outputs decode straight from flops, almost_full throttles the
// upstream reader early enough to absorb every read already in flight.
module m2_axis_skid_fifo
    import m2_input_buffer_pkg::*;
#(
    parameter int unsigned WIDTH    = 44,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             almost_full,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 pop;

    assign m_valid     = (count_q != '0);
    assign m_data      = mem_q[rd_ptr_q];
    assign pop         = m_valid & m_ready;
    assign almost_full = (count_q >= CNT_WIDTH'(AF_LEVEL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

endmodule

// File: rtl/m2_input_buffer.sv
// Analysis-side input buffer: ping-pong banks collect M/2 samples per frame, then each frame
// is replayed time-reversed with a branch index whose offset alternates between 0 and M/2.
module m2_input_buffer
    import m2_input_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FFT_SIZE_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
    input  logic                      s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [FFT_SIZE_WIDTH-2:0] phase_out,
    input  logic                      m_axis_tready
);

    localparam int unsigned ADDR_WIDTH  = FFT_SIZE_WIDTH - 2;
    localparam int unsigned PHASE_WIDTH = FFT_SIZE_WIDTH - 1;
    localparam int unsigned TAG_WIDTH   = PHASE_WIDTH + 1;

    logic                   run_q;
    logic [PHASE_WIDTH-1:0] half_q;
    logic [ADDR_WIDTH-1:0]  half_m1;

    logic                   wr_side_q;
    logic [ADDR_WIDTH-1:0]  wr_cnt_q;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   wr_fire;
    logic                   wr_last;
    logic [1:0]             full_q, full_d;

    rd_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic                   rd_side_q;
    logic                   offset_q;
    logic                   rd_fire;
    logic                   rd_last;
    logic [PHASE_WIDTH-1:0] rd_phase;

    logic [RAM_LATENCY-1:0] vld_pipe_q;
    logic [RAM_LATENCY-1:0] sel_pipe_q;
    logic [TAG_WIDTH-1:0]   tag_pipe_q [RAM_LATENCY];

    logic [DATA_WIDTH-1:0]  bank0_rdata, bank1_rdata, rdata_sel;
    logic                   fifo_af;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_out;

    assign half_m1 = ADDR_WIDTH'(half_q - 1'b1);

    // Ready comes only from flops so it never depends on the downstream handshake.
    assign s_axis_tready = run_q & ~full_q[wr_side_q];
    assign wr_fire       = s_axis_tvalid & s_axis_tready;
    assign wr_last       = (wr_cnt_q == half_m1);
    assign wr_addr       = half_m1 - wr_cnt_q;

    assign rd_fire  = (state_q != S_IDLE) & ~fifo_af;
    assign rd_last  = (rd_addr_q == half_m1);
    assign rd_phase = PHASE_WIDTH'(rd_addr_q) + (offset_q ? half_q : '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_af) begin
                    if (!rd_side_q && full_q[0]) begin
                        state_d = S_READ0;
                    end else if (rd_side_q && full_q[1]) begin
                        state_d = S_READ1;
                    end
                end
            end
            S_READ0, S_READ1: begin
                if (rd_fire && rd_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Writer and reader always own different banks, so set and clear never collide.
    always_comb begin
        full_d = full_q;
        if (wr_fire && wr_last) begin
            full_d[wr_side_q] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_d[rd_side_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q      <= 1'b0;
            half_q     <= '0;
            wr_side_q  <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            rd_side_q  <= 1'b0;
            offset_q   <= 1'b0;
            vld_pipe_q <= '0;
            sel_pipe_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            run_q   <= 1'b1;
            half_q  <= PHASE_WIDTH'(fft_size >> 1);
            full_q  <= full_d;
            state_q <= state_d;
            if (wr_fire) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
                if (wr_last) begin
                    wr_side_q <= ~wr_side_q;
                end
            end
            if (rd_fire) begin
                rd_addr_q <= rd_last ? '0 : rd_addr_q + 1'b1;
                if (rd_last) begin
                    rd_side_q <= ~rd_side_q;
                    offset_q  <= ~offset_q;
                end
            end
            // Tag and bank select ride alongside the RAM read pipeline.
            vld_pipe_q    <= {vld_pipe_q[RAM_LATENCY-2:0], rd_fire};
            sel_pipe_q    <= {sel_pipe_q[RAM_LATENCY-2:0], rd_side_q};
            tag_pipe_q[0] <= {rd_phase, rd_last};
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    dp_block_read_first_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_fire & ~wr_side_q),
        .waddr (wr_addr),
        .wdata (s_axis_tdata),
        .raddr (rd_addr_q),
        .rdata (bank0_rdata)
    );

    dp_block_read_first_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_fire & wr_side_q),
        .waddr (wr_addr),
        .wdata (s_axis_tdata),
        .raddr (rd_addr_q),
        .rdata (bank1_rdata)
    );

    assign rdata_sel = sel_pipe_q[RAM_LATENCY-1] ? bank1_rdata : bank0_rdata;

    m2_axis_skid_fifo #(
        .WIDTH    (DATA_WIDTH + TAG_WIDTH),
        .DEPTH    (FIFO_DEPTH),
        .AF_LEVEL (FIFO_AF_LEVEL)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (vld_pipe_q[RAM_LATENCY-1]),
        .push_data   ({rdata_sel, tag_pipe_q[RAM_LATENCY-1]}),
        .almost_full (fifo_af),
        .m_valid     (m_axis_tvalid),
        .m_data      (fifo_out),
        .m_ready     (m_axis_tready)
    );

    assign {m_axis_tdata, phase_out, m_axis_tlast} = fifo_out;

endmodule

// File: tb/tb_m2_input_buffer.sv
// Self-checking bench for m2_input_buffer: directed and random traffic scored against a
// frame-level reversal/phase model.
module tb_m2_input_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] fft_size = 12'd16;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [10:0] phase_out;
    logic        m_axis_tready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] in_q[$];
    int          in_cyc[$];
    logic [31:0] out_d[$];
    logic [10:0] out_p[$];
    logic        out_l[$];
    int          out_cyc[$];
    int          hold_viol;
    int          in_stall;
    int          first_valid_cyc;
    logic        sready_at_stall_end;
    int          next_val;

    m2_input_buffer #(
        .DATA_WIDTH     (32),
        .FFT_SIZE_WIDTH (12)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fft_size      (fft_size),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .phase_out     (phase_out),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame f of accepted input, read back reversed; odd frames since reset are offset by h.
    function automatic logic [31:0] exp_data(input int j, input int h);
        int idx;
        idx = (j / h) * h + (h - 1 - (j % h));
        if (idx < in_q.size()) return in_q[idx];
        return 32'hdead_beef;
    endfunction

    function automatic logic [10:0] exp_phase(input int j, input int h);
        return 11'((j % h) + ((((j / h) % 2) == 1) ? h : 0));
    endfunction

    function automatic logic exp_last(input int j, input int h);
        return ((j % h) == (h - 1));
    endfunction

    task automatic clear_q();
        in_q.delete(); in_cyc.delete();
        out_d.delete(); out_p.delete(); out_l.delete(); out_cyc.delete();
        next_val = 0;
    endtask

    task automatic do_reset(input logic [11:0] fft);
        reset_n = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        fft_size = fft;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 clear_q();
    endtask

    // Drives and records traffic only; every test scores the recorded queues itself.
    task automatic run_traffic(input int n_in, input int n_out, input int pin, input int pout,
                               input int stall_start, input int stall_len, input int max_cycles,
                               input bit rnd);
        int          sent;
        bit          pv;
        bit          in_fired;
        logic [31:0] pd;
        logic [10:0] pp;
        logic        pl;
        sent = 0; pv = 0; pd = '0; pp = '0; pl = 0;
        hold_viol = 0; in_stall = 0; first_valid_cyc = -1; sready_at_stall_end = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            if (sent == n_in && out_d.size() >= n_out) break;
            if (!s_axis_tvalid && sent < n_in && int'($urandom_range(99)) < pin) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = rnd ? $urandom : 32'(next_val);
            end
            if (pv && (!m_axis_tvalid || m_axis_tdata !== pd || phase_out !== pp ||
                       m_axis_tlast !== pl)) hold_viol++;
            m_axis_tready = (out_d.size() < n_out) &&
                            !(k >= stall_start && k < stall_start + stall_len) &&
                            (int'($urandom_range(99)) < pout);
            pv = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; pp = phase_out; pl = m_axis_tlast;
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_axis_tvalid && !s_axis_tready) in_stall++;
            if (k == stall_start + stall_len - 1) sready_at_stall_end = s_axis_tready;
            in_fired = s_axis_tvalid && s_axis_tready;
            if (in_fired) begin
                in_q.push_back(s_axis_tdata);
                in_cyc.push_back(cyc);
                sent++;
                next_val++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_d.push_back(m_axis_tdata);
                out_p.push_back(phase_out);
                out_l.push_back(m_axis_tlast);
                out_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (in_fired) s_axis_tvalid = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        fft_size = 12'd16;
        reset_n = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++;
            $display("FAIL reset_s_tready: got %b expected 0", s_axis_tready); end
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_m_tvalid: got %b expected 0", m_axis_tvalid); end
        n_tests++; if (m_axis_tlast !== 1'b0) begin n_fail++;
            $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        n_tests++; if (phase_out !== 11'd0) begin n_fail++;
            $display("FAIL reset_phase: got %0d expected 0", phase_out); end
        n_tests++; if (m_axis_tdata !== 32'd0) begin n_fail++;
            $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++;
            $display("FAIL post_reset_s_tready: got %b expected 1", s_axis_tready); end
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_m_tvalid: got %b expected 0", m_axis_tvalid); end
    endtask

    // Three frames at M=16: reversal, offset toggle and first-output latency.
    task automatic test_order();
        int lat;
        do_reset(12'd16);
        run_traffic(24, 24, 100, 100, -100, 0, 2000, 1'b0);
        n_tests++; if (out_d.size() != 24) begin n_fail++;
            $display("FAIL order_count: got %0d expected 24", out_d.size()); end
        lat = (in_cyc.size() >= 8) ? first_valid_cyc - (in_cyc[7] + 1) : -1;
        n_tests++; if (lat != 5) begin n_fail++;
            $display("FAIL order_latency: got %0d expected 5", lat); end
        for (int j = 0; j < out_d.size(); j++) begin
            n_tests++; if (out_d[j] !== 32'((j / 8) * 8 + 7 - (j % 8))) begin n_fail++;
                $display("FAIL order_data[%0d]: got %0d expected %0d", j, out_d[j],
                         (j / 8) * 8 + 7 - (j % 8)); end
            n_tests++; if (out_p[j] !== exp_phase(j, 8)) begin n_fail++;
                $display("FAIL order_phase[%0d]: got %0d expected %0d", j, out_p[j],
                         exp_phase(j, 8)); end
            n_tests++; if (out_l[j] !== exp_last(j, 8)) begin n_fail++;
                $display("FAIL order_tlast[%0d]: got %b expected %b", j, out_l[j],
                         exp_last(j, 8)); end
        end
    endtask

    // M=2048 streaming: output contiguous inside a frame, one idle slot between frames.
    task automatic test_large();
        int gap_viol;
        int bad;
        gap_viol = 0; bad = 0;
        do_reset(12'd2048);
        run_traffic(3072, 3072, 100, 100, -100, 0, 8000, 1'b1);
        n_tests++; if (out_d.size() != 3072) begin n_fail++;
            $display("FAIL large_count: got %0d expected 3072", out_d.size()); end
        n_tests++; if (in_stall > 3) begin n_fail++;
            $display("FAIL large_in_stall: got %0d expected <= 3", in_stall); end
        for (int j = 1; j < out_cyc.size(); j++) begin
            if (out_cyc[j] - out_cyc[j-1] > (((j % 1024) == 0) ? 2 : 1)) gap_viol++;
        end
        n_tests++; if (gap_viol != 0) begin n_fail++;
            $display("FAIL large_gaps: got %0d gaps expected 0", gap_viol); end
        for (int j = 0; j < out_d.size(); j++) begin
            if (out_d[j] !== exp_data(j, 1024) || out_p[j] !== exp_phase(j, 1024) ||
                out_l[j] !== exp_last(j, 1024)) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++;
            $display("FAIL large_stream: got %0d wrong outputs expected 0", bad); end
    endtask

    task automatic test_backpressure();
        do_reset(12'd16);
        run_traffic(48, 48, 100, 100, 12, 40, 3000, 1'b1);
        n_tests++; if (out_d.size() != 48) begin n_fail++;
            $display("FAIL bp_count: got %0d expected 48", out_d.size()); end
        n_tests++; if (sready_at_stall_end !== 1'b0) begin n_fail++;
            $display("FAIL bp_s_tready: got %b expected 0", sready_at_stall_end); end
        n_tests++; if (hold_viol != 0) begin n_fail++;
            $display("FAIL bp_hold: got %0d violations expected 0", hold_viol); end
        for (int j = 0; j < out_d.size(); j++) begin
            n_tests++; if (out_d[j] !== exp_data(j, 8) || out_p[j] !== exp_phase(j, 8) ||
                           out_l[j] !== exp_last(j, 8)) begin n_fail++;
                $display("FAIL bp_out[%0d]: got %h/%0d/%b expected %h/%0d/%b", j, out_d[j],
                         out_p[j], out_l[j], exp_data(j, 8), exp_phase(j, 8), exp_last(j, 8));
            end
        end
    endtask

    task automatic test_random();
        do_reset(12'd8);
        run_traffic(4000, 4000, 50, 50, -100, 0, 40000, 1'b1);
        n_tests++; if (out_d.size() != 4000) begin n_fail++;
            $display("FAIL rand_count: got %0d expected 4000", out_d.size()); end
        n_tests++; if (hold_viol != 0) begin n_fail++;
            $display("FAIL rand_hold: got %0d violations expected 0", hold_viol); end
        for (int j = 0; j < out_d.size(); j++) begin
            n_tests++; if (out_d[j] !== exp_data(j, 4) || out_p[j] !== exp_phase(j, 4) ||
                           out_l[j] !== exp_last(j, 4)) begin n_fail++;
                $display("FAIL rand_out[%0d]: got %h/%0d/%b expected %h/%0d/%b", j, out_d[j],
                         out_p[j], out_l[j], exp_data(j, 4), exp_phase(j, 4), exp_last(j, 4));
            end
        end
    endtask

    task automatic test_midframe_reset();
        do_reset(12'd16);
        // Frames 0..2 plus five samples of frame 3; only two frames are drained.
        run_traffic(29, 16, 100, 100, -100, 0, 2000, 1'b1);
        n_tests++; if (out_d.size() != 16) begin n_fail++;
            $display("FAIL mid_pre_count: got %0d expected 16", out_d.size()); end
        for (int j = 0; j < out_d.size(); j++) begin
            n_tests++; if (out_d[j] !== exp_data(j, 8) || out_p[j] !== exp_phase(j, 8)) begin
                n_fail++;
                $display("FAIL mid_pre_out[%0d]: got %h/%0d expected %h/%0d", j, out_d[j],
                         out_p[j], exp_data(j, 8), exp_phase(j, 8)); end
        end
        repeat (8) @(posedge clk);
        #1;
        n_tests++; if (m_axis_tvalid !== 1'b1) begin n_fail++;
            $display("FAIL mid_pending_valid: got %b expected 1", m_axis_tvalid); end
        reset_n = 1'b0;
        #1;
        n_tests++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000) begin n_fail++;
            $display("FAIL mid_reset_flags: got %b expected 000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast}); end
        n_tests++; if (phase_out !== 11'd0 || m_axis_tdata !== 32'd0) begin n_fail++;
            $display("FAIL mid_reset_data: got %h/%0d expected 0/0", m_axis_tdata, phase_out);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 clear_q();
        run_traffic(16, 16, 100, 100, -100, 0, 2000, 1'b1);
        n_tests++; if (out_d.size() != 16) begin n_fail++;
            $display("FAIL mid_post_count: got %0d expected 16", out_d.size()); end
        for (int j = 0; j < out_d.size(); j++) begin
            n_tests++; if (out_d[j] !== exp_data(j, 8) || out_p[j] !== exp_phase(j, 8) ||
                           out_l[j] !== exp_last(j, 8)) begin n_fail++;
                $display("FAIL mid_post_out[%0d]: got %h/%0d/%b expected %h/%0d/%b", j,
                         out_d[j], out_p[j], out_l[j], exp_data(j, 8), exp_phase(j, 8),
                         exp_last(j, 8)); end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_large();
        test_backpressure();
        test_random();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
